// File: rtl/arith_tb_pkg.sv
// Shared types and constants for the arithmetic test sequencer.
//   state_e   : sequencer states (IDLE, RUN, DRAIN, DONE)
//   mode_e    : operand source (LFSR or counting index)
//   LFSR_MASK : Galois tap mask for x^32+x^22+x^2+x+1
//   CNT_W     : width of the pass/fail statistics counters
//   IDX_W     : width of the vector index
//   lfsr_next : one Galois step of the 32-bit LFSR
package arith_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_LFSR  = 1'b0,
        MODE_COUNT = 1'b1
    } mode_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int          CNT_W     = 32;
    localparam int          IDX_W     = 16;

    // Right-shifting Galois form: the bit shifted out feeds back through the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32_gen.sv
// 32-bit Galois LFSR operand generator.
//   clk   in  clock, rising edge
//   reset in  asynchronous active-high reset; register returns to RST_SEED
//   load  in  reload register from seed (takes priority over step)
//   step  in  advance one LFSR step
//   seed  in  32-bit reload value, must be non-zero
//   q     out current LFSR state
module lfsr32_gen
    import arith_tb_pkg::*;
#(
    parameter logic [31:0] RST_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= RST_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/arith_test_ctrl.sv
// Self-checking test sequencer for an arithmetic DUT/monitor pair.
// Issues one operand pair per cycle, then compares the monitor's reference
// result against its delayed DUT result CMP_LAT cycles later, keeping
// saturating pass/fail totals and a capture of the first mismatch.
//   clk, reset                 clock and asynchronous active-high reset
//   i_start, i_abort, i_mode   run control and operand source select
//   o_a, o_b                   registered operands to DUT and monitor
//   i_mon_o, i_dtm_o           reference and delayed DUT results
//   o_busy, o_done             RUN/DRAIN and DONE indications
//   o_pass_cnt, o_fail_cnt     compare totals
//   o_first_fail_*             index and values of first mismatch
//   o_any_fail                 sticky; first-fail fields valid
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for i_start; results from an aborted run held
// ST_RUN   | one vector issued per cycle, index 0..N_VECTORS-1
// ST_DRAIN | CMP_LAT cycles for in-flight compares to land
// ST_DONE  | results held; i_start begins a new run
module arith_test_ctrl
    import arith_tb_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          N_VECTORS = 256,
    parameter int          CMP_LAT   = 1,
    parameter logic [31:0] SEED_A    = 32'h0000_0001,
    parameter logic [31:0] SEED_B    = 32'h0000_ACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    input  logic [WIDTH-1:0] i_mon_o,
    input  logic [WIDTH-1:0] i_dtm_o,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_pass_cnt,
    output logic [31:0]      o_fail_cnt,
    output logic [15:0]      o_first_fail_idx,
    output logic [WIDTH-1:0] o_first_fail_mon,
    output logic [WIDTH-1:0] o_first_fail_dut,
    output logic             o_any_fail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS - 1);
    localparam logic [3:0]       DRAIN_LD = 4'(CMP_LAT);

    state_e                        state_q;
    mode_e                         mode_q;
    logic [IDX_W-1:0]              idx_q;
    logic [3:0]                    drain_q;
    logic                          busy_q;
    logic                          done_q;
    logic [WIDTH-1:0]              a_q;
    logic [WIDTH-1:0]              b_q;

    logic [CMP_LAT-1:0]            pipe_vld_q;
    logic [CMP_LAT-1:0][IDX_W-1:0] pipe_idx_q;

    logic [CNT_W-1:0]              pass_q;
    logic [CNT_W-1:0]              fail_q;
    logic [IDX_W-1:0]              ff_idx_q;
    logic [WIDTH-1:0]              ff_mon_q;
    logic [WIDTH-1:0]              ff_dut_q;
    logic                          any_fail_q;

    logic                          start_acc;
    logic                          abort_acc;
    logic                          issue;
    logic                          cmp_fire;
    logic                          cmp_eq;
    logic [31:0]                   lfsr_a;
    logic [31:0]                   lfsr_b;
    logic [WIDTH-1:0]              idx_w;
    logic [WIDTH-1:0]              opa_w;
    logic [WIDTH-1:0]              opb_w;

    // Start is only honoured when no run is in progress; abort only when one is.
    assign start_acc = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort_acc = i_abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign issue     = (state_q == ST_RUN) && !abort_acc;
    // A compare landing on the abort edge is dropped so totals freeze as seen.
    assign cmp_fire  = pipe_vld_q[CMP_LAT-1] && !abort_acc;
    assign cmp_eq    = (i_mon_o == i_dtm_o);

    lfsr32_gen #(.RST_SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .step  (issue),
        .seed  (SEED_A),
        .q     (lfsr_a)
    );

    lfsr32_gen #(.RST_SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .step  (issue),
        .seed  (SEED_B),
        .q     (lfsr_b)
    );

    generate
        if (WIDTH > IDX_W) begin : g_idx_ext
            assign idx_w = {{(WIDTH-IDX_W){1'b0}}, idx_q};
        end else begin : g_idx_trunc
            assign idx_w = idx_q[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        opa_w = lfsr_a[WIDTH-1:0];
        opb_w = lfsr_b[WIDTH-1:0];
        if (mode_q == MODE_COUNT) begin
            opa_w = idx_w;
            opb_w = idx_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LFSR;
            idx_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_q <= ST_RUN;
                        mode_q  <= mode_e'(i_mode);
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q   <= opa_w;
                        b_q   <= opb_w;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRAIN_LD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q == 4'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Valid/index shift register aligning each issued vector with its results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else if (abort_acc) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_idx_q[0] <= idx_q;
            for (int i = 1; i < CMP_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q     <= '0;
            fail_q     <= '0;
            ff_idx_q   <= '0;
            ff_mon_q   <= '0;
            ff_dut_q   <= '0;
            any_fail_q <= 1'b0;
        end else if (start_acc) begin
            pass_q     <= '0;
            fail_q     <= '0;
            ff_idx_q   <= '0;
            ff_mon_q   <= '0;
            ff_dut_q   <= '0;
            any_fail_q <= 1'b0;
        end else if (cmp_fire) begin
            if (cmp_eq) begin
                if (pass_q != '1) begin
                    pass_q <= pass_q + 1'b1;
                end
            end else begin
                if (fail_q != '1) begin
                    fail_q <= fail_q + 1'b1;
                end
                if (!any_fail_q) begin
                    ff_idx_q   <= pipe_idx_q[CMP_LAT-1];
                    ff_mon_q   <= i_mon_o;
                    ff_dut_q   <= i_dtm_o;
                    any_fail_q <= 1'b1;
                end
            end
        end
    end

    assign o_a              = a_q;
    assign o_b              = b_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_pass_cnt       = pass_q;
    assign o_fail_cnt       = fail_q;
    assign o_first_fail_idx = ff_idx_q;
    assign o_first_fail_mon = ff_mon_q;
    assign o_first_fail_dut = ff_dut_q;
    assign o_any_fail       = any_fail_q;

endmodule

// File: tb/tb_arith_test_ctrl.sv
// Directed bench for arith_test_ctrl: a short counting-mode instance (N=8)
// and a long LFSR-mode instance (N=4096), both with CMP_LAT=1 and a
// combinational monitor model that injects errors when a[0]&b[0].
module tb_arith_test_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // short counting instance
    logic          s_start, s_abort, s_mode, dut_sel;
    logic [W-1:0]  s_a, s_b, s_mon, s_dtm, s_ffm, s_ffd;
    logic          s_busy, s_done, s_any;
    logic [31:0]   s_pass, s_fail;
    logic [15:0]   s_ffi;

    // long LFSR instance
    logic          l_start, l_abort, l_mode;
    logic [W-1:0]  l_a, l_b, l_mon, l_dtm, l_ffm, l_ffd;
    logic          l_busy, l_done, l_any;
    logic [31:0]   l_pass, l_fail;
    logic [15:0]   l_ffi;

    always_comb begin
        s_mon = (s_a[0] & s_b[0]) ? s_b : s_a + s_b;
        s_dtm = dut_sel ? ((s_a[0] & s_b[0]) ? s_b : s_a + s_b) : s_a + s_b;
        l_mon = (l_a[0] & l_b[0]) ? l_b : l_a + l_b;
        l_dtm = l_a + l_b;
    end

    arith_test_ctrl #(.WIDTH(W), .N_VECTORS(8), .CMP_LAT(1)) dut_s (
        .clk(clk), .reset(reset), .i_start(s_start), .i_abort(s_abort), .i_mode(s_mode),
        .o_a(s_a), .o_b(s_b), .i_mon_o(s_mon), .i_dtm_o(s_dtm),
        .o_busy(s_busy), .o_done(s_done), .o_pass_cnt(s_pass), .o_fail_cnt(s_fail),
        .o_first_fail_idx(s_ffi), .o_first_fail_mon(s_ffm), .o_first_fail_dut(s_ffd),
        .o_any_fail(s_any)
    );

    arith_test_ctrl #(.WIDTH(W), .N_VECTORS(4096), .CMP_LAT(1)) dut_l (
        .clk(clk), .reset(reset), .i_start(l_start), .i_abort(l_abort), .i_mode(l_mode),
        .o_a(l_a), .o_b(l_b), .i_mon_o(l_mon), .i_dtm_o(l_dtm),
        .o_busy(l_busy), .o_done(l_done), .o_pass_cnt(l_pass), .o_fail_cnt(l_fail),
        .o_first_fail_idx(l_ffi), .o_first_fail_mon(l_ffm), .o_first_fail_dut(l_ffd),
        .o_any_fail(l_any)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows a short run whose start was accepted cyc0 edges ago; done must
    // appear 10 edges after the start edge.
    task automatic s_follow(input string tag, input bit detail, input int cyc0);
        int cyc;
        int exp_tot;
        cyc = cyc0;
        while (!s_done && cyc < 40) begin
            tick();
            cyc++;
            if (detail && cyc <= 9) begin
                chk_val({tag, "_oa"}, s_a, 32'((cyc - 1 > 7) ? 7 : cyc - 1));
                exp_tot = (cyc <= 1) ? 0 : ((cyc - 1 > 8) ? 8 : cyc - 1);
                chk_val({tag, "_tot"}, s_pass + s_fail, 32'(exp_tot));
                chk_val({tag, "_busy"}, 32'(s_busy), 32'd1);
            end
        end
        chk_val({tag, "_lat"}, 32'(cyc), 32'd10);
        chk_val({tag, "_busy_end"}, 32'(s_busy), 32'd0);
    endtask

    task automatic s_pulse_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic s_chk_res(input string tag, input logic [31:0] p, input logic [31:0] f,
                             input logic any, input logic [15:0] idx,
                             input logic [31:0] m, input logic [31:0] d);
        chk_val({tag, "_pass"}, s_pass, p);
        chk_val({tag, "_fail"}, s_fail, f);
        chk_val({tag, "_any"}, 32'(s_any), 32'(any));
        chk_val({tag, "_ffi"}, 32'(s_ffi), 32'(idx));
        chk_val({tag, "_ffm"}, s_ffm, m);
        chk_val({tag, "_ffd"}, s_ffd, d);
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
        logic [31:0] r;
        r = {1'b0, x[31:1]};
        if (x[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    int          m_fail;
    int          m_first;
    logic [31:0] m_fmon, m_fdut;

    task automatic model_lfsr();
        logic [31:0] a, b, mv, dv;
        a = 32'h0000_0001;
        b = 32'h0000_ACE1;
        m_fail  = 0;
        m_first = -1;
        m_fmon  = 0;
        m_fdut  = 0;
        for (int k = 0; k < 4096; k++) begin
            mv = (a[0] & b[0]) ? b : a + b;
            dv = a + b;
            if (mv != dv) begin
                if (m_first < 0) begin
                    m_first = k;
                    m_fmon  = mv;
                    m_fdut  = dv;
                end
                m_fail++;
            end
            a = lfsr_adv(a);
            b = lfsr_adv(b);
        end
    endtask

    task automatic l_run(input string tag);
        int cyc;
        l_start = 1'b1;
        tick();
        l_start = 1'b0;
        cyc = 0;
        while (!l_done && cyc < 4200) begin
            tick();
            cyc++;
            if (cyc == 1) chk_val({tag, "_a0"}, l_a, 32'h0000_0001);
            if (cyc == 2) begin
                chk_val({tag, "_a1"}, l_a, 32'h8020_0003);
                chk_val({tag, "_b1"}, l_b, 32'h8020_5673);
            end
        end
        chk_val({tag, "_lat"}, 32'(cyc), 32'd4098);
        chk_val({tag, "_total"}, l_pass + l_fail, 32'd4096);
        chk_val({tag, "_fail"}, l_fail, 32'(m_fail));
        chk_val({tag, "_frange"}, 32'((l_fail >= 896) && (l_fail <= 1152)), 32'd1);
        chk_val({tag, "_ffi"}, 32'(l_ffi), 32'(m_first));
        chk_val({tag, "_ffm"}, l_ffm, m_fmon);
        chk_val({tag, "_ffd"}, l_ffd, m_fdut);
        chk_val({tag, "_any"}, 32'(l_any), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_mode = 1'b1; dut_sel = 1'b0;
        l_start = 1'b0; l_abort = 1'b0; l_mode = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // reset state
        chk_val("rst_busy", 32'(s_busy), 32'd0);
        chk_val("rst_done", 32'(s_done), 32'd0);
        chk_val("rst_oa", s_a, 32'd0);
        s_chk_res("rst", 0, 0, 1'b0, 16'd0, 0, 0);

        // counting mode with error-injecting monitor
        s_pulse_start();
        chk_val("r1_busy0", 32'(s_busy), 32'd1);
        s_follow("r1", 1'b1, 0);
        chk_val("r1_oa_hold", s_a, 32'd7);
        chk_val("r1_done", 32'(s_done), 32'd1);
        s_chk_res("r1", 4, 4, 1'b1, 16'd1, 32'd1, 32'd2);

        // DUT matches the monitor's reference function
        dut_sel = 1'b1;
        s_pulse_start();
        s_follow("r2", 1'b0, 0);
        s_chk_res("r2", 8, 0, 1'b0, 16'd0, 0, 0);
        dut_sel = 1'b0;

        // abort on the fifth RUN edge
        s_pulse_start();
        repeat (4) tick();
        chk_val("ab_pre_pass", s_pass, 32'd2);
        chk_val("ab_pre_fail", s_fail, 32'd1);
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        chk_val("ab_busy", 32'(s_busy), 32'd0);
        chk_val("ab_done", 32'(s_done), 32'd0);
        chk_val("ab_pass", s_pass, 32'd2);
        chk_val("ab_fail", s_fail, 32'd1);
        repeat (5) tick();
        chk_val("ab_hold_pass", s_pass, 32'd2);
        chk_val("ab_hold_fail", s_fail, 32'd1);
        chk_val("ab_hold_busy", 32'(s_busy), 32'd0);
        // abort while idle does nothing
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        chk_val("ab_idle_busy", 32'(s_busy), 32'd0);
        chk_val("ab_idle_pass", s_pass, 32'd2);

        // start held for three cycles: a single run
        s_start = 1'b1;
        tick();
        tick();
        tick();
        s_start = 1'b0;
        s_follow("hold", 1'b0, 2);
        s_chk_res("hold", 4, 4, 1'b1, 16'd1, 32'd1, 32'd2);
        repeat (3) tick();
        chk_val("hold_once", 32'(s_done), 32'd1);

        // restart from DONE clears and reproduces
        s_pulse_start();
        chk_val("rs_clr_pass", s_pass, 32'd0);
        chk_val("rs_clr_fail", s_fail, 32'd0);
        chk_val("rs_clr_any", 32'(s_any), 32'd0);
        s_follow("rs", 1'b0, 0);
        s_chk_res("rs", 4, 4, 1'b1, 16'd1, 32'd1, 32'd2);

        // reset in DRAIN
        s_pulse_start();
        repeat (8) tick();
        chk_val("dr_busy", 32'(s_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_val("dr_rst_busy", 32'(s_busy), 32'd0);
        chk_val("dr_rst_done", 32'(s_done), 32'd0);
        chk_val("dr_rst_oa", s_a, 32'd0);
        s_chk_res("dr_rst", 0, 0, 1'b0, 16'd0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        s_pulse_start();
        s_follow("dr_clean", 1'b1, 0);
        s_chk_res("dr_clean", 4, 4, 1'b1, 16'd1, 32'd1, 32'd2);

        // LFSR mode, long run, then repeat with the same seeds
        model_lfsr();
        l_run("lf1");
        l_run("lf2");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
